// File: rtl/br_pkg.sv
// Shared branch-unit definitions: branch codes, 2-bit counter states, BTB entry layout.
package br_pkg;

  // 3-bit branch codes carried from decode to EX; 3'b011 is decoded as "none".
  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BNE  = 3'b101;
  localparam logic [2:0] BR_BLT  = 3'b110;
  localparam logic [2:0] BR_BGE  = 3'b111;

  // Saturating direction counter states; bit 1 is the taken prediction.
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Tag storage is sized for the smallest sensible index (pc[31:2]); narrower tags are
  // zero-extended so the entry layout does not depend on the BTB index width.
  localparam int unsigned TAG_MAX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           ctr;
  } btb_entry_t;

  // Saturating counter step: +1 on taken, -1 on not taken, clamped to SNT..ST.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/br_resolve.sv
// EX-stage branch resolution: actual direction, correct next PC and mispredict flag.
module br_resolve
  import br_pkg::*;
(
  input  logic        en,
  input  logic [2:0]  branch,
  input  logic        zero,
  input  logic        less,
  input  logic [31:0] pc,
  input  logic [31:0] target,
  input  logic [31:0] pred_pc,
  output logic        resolve,
  output logic        is_jump,
  output logic        taken,
  output logic [31:0] actual_pc,
  output logic        mispredict
);

  logic        is_branch;
  logic [31:0] seq_pc;

  // Sequential PC; 32-bit add so the carry drops at the top of the address space.
  assign seq_pc = pc + 32'd4;

  // Decode branch code into control-flow class and actual direction.
  always_comb begin
    is_branch = 1'b0;
    is_jump   = 1'b0;
    taken     = 1'b0;
    case (branch)
      BR_JAL, BR_JALR: begin
        is_branch = 1'b1;
        is_jump   = 1'b1;
        taken     = 1'b1;
      end
      BR_BEQ: begin
        is_branch = 1'b1;
        taken     = zero;
      end
      BR_BNE: begin
        is_branch = 1'b1;
        taken     = ~zero;
      end
      BR_BLT: begin
        is_branch = 1'b1;
        taken     = less;
      end
      BR_BGE: begin
        is_branch = 1'b1;
        taken     = ~less;
      end
      default: begin
        is_branch = 1'b0;
      end
    endcase
  end

  // Compare the real next PC against what fetch assumed.
  always_comb begin
    resolve    = en & is_branch;
    actual_pc  = taken ? target : seq_pc;
    mispredict = resolve & (actual_pc != pred_pc);
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Fetch-redirect controller: BTB lookup at IF, resolution/redirect and BTB update at EX.
module branch_predict_ctrl
  import br_pkg::*;
#(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_pc,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic [31:0]      ex_pc,
  input  logic [2:0]       ex_branch,
  input  logic             ex_zero,
  input  logic             ex_less,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_pc,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  btb_entry_t btb_q [ENTRIES];

  logic [IDX_W-1:0]     if_idx;
  logic [IDX_W-1:0]     ex_idx;
  logic [TAG_MAX_W-1:0] if_tag;
  logic [TAG_MAX_W-1:0] ex_tag;
  btb_entry_t           if_entry;
  btb_entry_t           ex_entry;
  logic                 if_hit;
  logic                 ex_hit;

  logic                 res;
  logic                 res_jump;
  logic                 res_taken;
  logic [31:0]          res_pc;
  logic                 res_mispredict;

  btb_entry_t           upd_entry;
  logic                 upd_we;

  logic [CNT_W-1:0]     branch_cnt_q;
  logic [CNT_W-1:0]     mispred_cnt_q;

  // The carried prediction bit is implied by ex_pred_pc; it is kept on the port for debug.
  logic                 unused_pred_taken;
  assign unused_pred_taken = ex_pred_taken;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign if_tag = TAG_MAX_W'(if_pc[31:IDX_W+2]);
  assign ex_tag = TAG_MAX_W'(ex_pc[31:IDX_W+2]);

  assign if_entry = btb_q[if_idx];
  assign ex_entry = btb_q[ex_idx];

  // IF lookup reads the registered table, so a same-cycle EX write is not bypassed.
  always_comb begin
    if_hit     = if_entry.valid && (if_entry.tag == if_tag);
    pred_taken = if_hit && if_entry.ctr[1];
    pred_pc    = pred_taken ? if_entry.target : (if_pc + 32'd4);
  end

  br_resolve u_resolve (
    .en         (ex_valid & ~ex_stall),
    .branch     (ex_branch),
    .zero       (ex_zero),
    .less       (ex_less),
    .pc         (ex_pc),
    .target     (ex_target),
    .pred_pc    (ex_pred_pc),
    .resolve    (res),
    .is_jump    (res_jump),
    .taken      (res_taken),
    .actual_pc  (res_pc),
    .mispredict (res_mispredict)
  );

  // Redirect is combinational so the PC mux picks it up on the next edge; reset masks it.
  always_comb begin
    redirect    = res_mispredict & ~rst;
    redirect_pc = res_pc;
    flush_if_id = redirect;
    flush_id_ex = redirect;
  end

  // Build the replacement entry for the EX instruction's slot.
  always_comb begin
    ex_hit    = ex_entry.valid && (ex_entry.tag == ex_tag);
    upd_entry = ex_entry;
    upd_we    = 1'b0;
    if (res) begin
      if (ex_hit) begin
        upd_we = 1'b1;
        if (res_jump) begin
          upd_entry.ctr    = ST;
          upd_entry.target = ex_target;
        end else begin
          upd_entry.ctr = ctr_step(ex_entry.ctr, res_taken);
          if (res_taken) upd_entry.target = ex_target;
        end
      end else if (res_taken) begin
        // Not-taken misses are not allocated: they would only predict fall-through anyway.
        upd_we           = 1'b1;
        upd_entry.valid  = 1'b1;
        upd_entry.tag    = ex_tag;
        upd_entry.target = ex_target;
        upd_entry.ctr    = res_jump ? ST : WT;
      end
    end
  end

  // BTB storage; reset clears valid and direction state, targets/tags are don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        btb_q[i].valid <= 1'b0;
        btb_q[i].ctr   <= SNT;
      end
    end else if (upd_we) begin
      btb_q[ex_idx] <= upd_entry;
    end
  end

  // Performance counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (res) begin
      branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (res_mispredict) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
